// File: rtl/load_hazard_ctrl.sv
// Load-use hazard controller: sizes ID-stage bubbles per consumer class
// and load distance, and freezes the back end while data memory is busy.
module load_hazard_ctrl #(
  parameter int OPW         = 7,
  parameter int RW          = 5,
  parameter int BR_BUBBLES  = 1,
  parameter int ALU_BUBBLES = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   if_id_opcode,
  input  logic [RW-1:0]    if_id_rs1,
  input  logic [RW-1:0]    if_id_rs2,
  input  logic             if_id_rs1_used,
  input  logic             if_id_rs2_used,
  input  logic             id_ex_memrd,
  input  logic [RW-1:0]    id_ex_rd,
  input  logic             ex_mem_memrd,
  input  logic [RW-1:0]    ex_mem_rd,
  input  logic             mem_busy,
  output logic             PC_Write,
  output logic             if_id_Write,
  output logic             id_ex_cntrl_mux_sel,
  output logic             pipe_hold,
  output logic             hazard_active,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HAZ  = 2'd1,
    MEMW = 2'd2
  } state_e;

  localparam logic [OPW-1:0] OP_BEQ = OPW'(7'h44);
  localparam logic [OPW-1:0] OP_BNE = OPW'(7'h45);
  localparam logic [OPW-1:0] OP_BLT = OPW'(7'h50);
  localparam logic [OPW-1:0] OP_BGE = OPW'(7'h51);
  localparam logic [OPW-1:0] OP_JR  = OPW'(7'h08);

  localparam logic [1:0] BR_N  = 2'(BR_BUBBLES);
  localparam logic [1:0] ALU_N = 2'(ALU_BUBBLES);

  state_e           state_q, state_d;
  state_e           saved_q, saved_d;
  state_e           eff;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic       is_br;
  logic       rs1_cmp, rs2_cmp;
  logic       id_ex_hit, ex_mem_hit;
  logic [1:0] base, need;
  logic       bubble, wait_mem;

  always_comb begin
    is_br = if_id_opcode inside {OP_BEQ, OP_BNE, OP_BLT,
                                 OP_BGE, OP_JR};
    rs1_cmp = is_br | if_id_rs1_used;
    rs2_cmp = is_br | if_id_rs2_used;

    id_ex_hit = id_ex_memrd && (|id_ex_rd) &&
      ((rs1_cmp && id_ex_rd == if_id_rs1) ||
       (rs2_cmp && id_ex_rd == if_id_rs2));
    ex_mem_hit = ex_mem_memrd && (|ex_mem_rd) &&
      ((rs1_cmp && ex_mem_rd == if_id_rs1) ||
       (rs2_cmp && ex_mem_rd == if_id_rs2));

    base = is_br ? BR_N : ALU_N;
    need = 2'd0;
    if (id_ex_hit) begin
      need = base;
    end else if (ex_mem_hit && base != 2'd0) begin
      need = base - 2'd1;
    end
  end

  // MEMW resumes as whichever state it interrupted.
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    rem_d    = rem_q;
    bubble   = 1'b0;
    wait_mem = 1'b0;
    eff      = (state_q == MEMW) ? saved_q : state_q;

    if (mem_busy) begin
      wait_mem = 1'b1;
      state_d  = MEMW;
      saved_d  = eff;
    end else if (eff == HAZ) begin
      bubble = 1'b1;
      if (rem_q <= 2'd1) begin
        state_d = RUN;
        rem_d   = 2'd0;
      end else begin
        state_d = HAZ;
        rem_d   = rem_q - 2'd1;
      end
    end else begin
      state_d = RUN;
      if (need != 2'd0) begin
        bubble = 1'b1;
        if (need > 2'd1) begin
          state_d = HAZ;
          rem_d   = need - 2'd1;
        end
      end
    end

    if (!rst) begin
      state_d  = RUN;
      saved_d  = RUN;
      rem_d    = 2'd0;
      bubble   = 1'b0;
      wait_mem = 1'b0;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (bubble && stall_count_q != '1) begin
      stall_count_d = stall_count_q + 1'b1;
    end
    if (!rst) begin
      stall_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    saved_q       <= saved_d;
    rem_q         <= rem_d;
    stall_count_q <= stall_count_d;
  end

  assign PC_Write            = ~(bubble | wait_mem);
  assign if_id_Write         = ~(bubble | wait_mem);
  assign id_ex_cntrl_mux_sel = bubble;
  assign pipe_hold           = wait_mem;
  assign hazard_active       = bubble;
  assign stall_count         = stall_count_q;

endmodule

// File: tb/tb_load_hazard_ctrl.sv
// Bench for load_hazard_ctrl: three parameterisations share one stimulus
// stream and are checked against an owed-bubble reference model.
module tb_load_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [4:0] rs1, rs2;
  logic       u1, u2;
  logic       im, em, mb;
  logic [4:0] ird, erd;

  logic        pcw [3];
  logic        ifw [3];
  logic        mux [3];
  logic        hold[3];
  logic        hact[3];
  logic [15:0] sc  [3];
  logic [15:0] sc_a, sc_b;
  logic [1:0]  sc_c;

  int checks   = 0;
  int failures = 0;

  int br_n [3] = '{1, 2, 3};
  int alu_n[3] = '{0, 1, 1};
  int maxc [3] = '{65535, 65535, 3};
  int pend [3] = '{0, 0, 0};
  int cnt  [3] = '{0, 0, 0};

  load_hazard_ctrl #(.BR_BUBBLES(1), .ALU_BUBBLES(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .if_id_opcode(op),
    .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_rs1_used(u1), .if_id_rs2_used(u2),
    .id_ex_memrd(im), .id_ex_rd(ird),
    .ex_mem_memrd(em), .ex_mem_rd(erd), .mem_busy(mb),
    .PC_Write(pcw[0]), .if_id_Write(ifw[0]),
    .id_ex_cntrl_mux_sel(mux[0]), .pipe_hold(hold[0]),
    .hazard_active(hact[0]), .stall_count(sc_a)
  );

  load_hazard_ctrl #(.BR_BUBBLES(2), .ALU_BUBBLES(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .if_id_opcode(op),
    .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_rs1_used(u1), .if_id_rs2_used(u2),
    .id_ex_memrd(im), .id_ex_rd(ird),
    .ex_mem_memrd(em), .ex_mem_rd(erd), .mem_busy(mb),
    .PC_Write(pcw[1]), .if_id_Write(ifw[1]),
    .id_ex_cntrl_mux_sel(mux[1]), .pipe_hold(hold[1]),
    .hazard_active(hact[1]), .stall_count(sc_b)
  );

  load_hazard_ctrl #(.BR_BUBBLES(3), .ALU_BUBBLES(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .if_id_opcode(op),
    .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_rs1_used(u1), .if_id_rs2_used(u2),
    .id_ex_memrd(im), .id_ex_rd(ird),
    .ex_mem_memrd(em), .ex_mem_rd(erd), .mem_busy(mb),
    .PC_Write(pcw[2]), .if_id_Write(ifw[2]),
    .id_ex_cntrl_mux_sel(mux[2]), .pipe_hold(hold[2]),
    .hazard_active(hact[2]), .stall_count(sc_c)
  );

  assign sc[0] = sc_a;
  assign sc[1] = sc_b;
  assign sc[2] = {14'd0, sc_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int need_f(input int i);
    bit br, c1, c2, h_ie, h_em;
    int base;
    br = (op == 7'h44) || (op == 7'h45) || (op == 7'h50) ||
         (op == 7'h51) || (op == 7'h08);
    c1 = br || u1;
    c2 = br || u2;
    h_ie = im && ird != 0 &&
           ((c1 && ird == rs1) || (c2 && ird == rs2));
    h_em = em && erd != 0 &&
           ((c1 && erd == rs1) || (c2 && erd == rs2));
    base = br ? br_n[i] : alu_n[i];
    if (h_ie) return base;
    if (h_em) return (base > 0) ? base - 1 : 0;
    return 0;
  endfunction

  task automatic cyc(input logic r, input logic b,
                     input logic [6:0] o,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input logic f1, input logic f2,
                     input logic lm, input logic [4:0] lrd,
                     input logic xm, input logic [4:0] xrd);
    bit bub, wt;
    int nd;
    rst = r; mb = b; op = o; rs1 = a1; rs2 = a2;
    u1 = f1; u2 = f2; im = lm; ird = lrd; em = xm; erd = xrd;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bub = 0;
      wt  = 0;
      if (!r) begin
        pend[i] = 0;
      end else if (b) begin
        wt = 1;
      end else if (pend[i] > 0) begin
        bub = 1;
        pend[i]--;
      end else begin
        nd = need_f(i);
        if (nd > 0) begin
          bub = 1;
          pend[i] = nd - 1;
        end
      end
      check($sformatf("out%0d", i),
            {27'd0, pcw[i], ifw[i], mux[i], hold[i], hact[i]},
            {27'd0, ~(bub | wt), ~(bub | wt), bub, wt, bub});
      check($sformatf("cnt%0d", i), {16'd0, sc[i]}, cnt[i]);
      if (!r) cnt[i] = 0;
      else if (bub && cnt[i] < maxc[i]) cnt[i]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic br_haz();
    cyc(1, 0, 7'h44, 5, 0, 0, 0, 1, 5, 0, 0);
  endtask

  logic [4:0] regs[4] = '{5'd0, 5'd5, 5'd7, 5'd9};
  logic [6:0] ops [8] = '{7'h44, 7'h45, 7'h50, 7'h51,
                          7'h08, 7'h33, 7'h03, 7'h13};

  initial begin
    rst = 0; mb = 0; op = 0; rs1 = 0; rs2 = 0;
    u1 = 0; u2 = 0; im = 0; ird = 0; em = 0; erd = 0;
    @(posedge clk);
    #1;
    rst_cyc();
    rst_cyc();

    br_haz();
    idle(3);
    check("br_cnt_a", {16'd0, sc[0]}, 1);
    check("br_cnt_b", {16'd0, sc[1]}, 2);
    check("br_cnt_c", {16'd0, sc[2]}, 3);
    rst_cyc();

    cyc(1, 0, 7'h44, 5, 0, 0, 0, 0, 0, 1, 5);
    idle(3);
    check("exm_cnt_a", {16'd0, sc[0]}, 0);
    check("exm_cnt_b", {16'd0, sc[1]}, 1);
    check("exm_cnt_c", {16'd0, sc[2]}, 2);
    rst_cyc();

    cyc(1, 0, 7'h33, 7, 9, 1, 0, 1, 7, 0, 0);
    idle(2);
    check("alu_cnt_a", {16'd0, sc[0]}, 0);
    check("alu_cnt_b", {16'd0, sc[1]}, 1);
    cyc(1, 0, 7'h33, 7, 9, 0, 1, 1, 7, 0, 0);
    idle(1);
    cyc(1, 0, 7'h44, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 7'h33, 0, 0, 1, 1, 1, 0, 1, 0);
    idle(1);
    rst_cyc();

    br_haz();
    for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    check("busy_cnt_c", {16'd0, sc[2]}, 3);
    check("busy_cnt_a", {16'd0, sc[0]}, 1);

    br_haz();
    rst_cyc();
    idle(1);
    check("rst_cnt_b", {16'd0, sc[1]}, 0);
    check("rst_cnt_c", {16'd0, sc[2]}, 0);

    br_haz();
    idle(3);
    br_haz();
    idle(3);
    check("sat_cnt_c", {16'd0, sc[2]}, 3);

    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 49) != 0,
          $urandom_range(0, 5) == 0,
          ops[$urandom_range(0, 7)],
          regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), regs[$urandom_range(0, 3)],
          1'($urandom_range(0, 1)), regs[$urandom_range(0, 3)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_hazard_ctrl.md
# load_hazard_ctrl

Parametrised load-use hazard controller for the 5-stage pipelined CPU. It sits beside the ID stage and generalises single-bubble load→branch/jr detection to configurable bubble counts per consumer class and to load distances of one or two stages. It also freezes the whole pipeline while data memory is busy. A counter FSM holds a stall across several cycles after the load has left ID/EX, and a saturating performance counter reports the number of inserted bubbles.

## Interface
Parameters:
- OPW, 7: opcode width.
- RW, 5: register address width.
- BR_BUBBLES, 1: bubbles for a load in ID/EX feeding a branch-class instruction in IF/ID. Legal range 1..3.
- ALU_BUBBLES, 0: bubbles for a load in ID/EX feeding any other instruction in IF/ID. Legal range 0..3.
- CNT_W, 16: width of stall_count.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- if_id_opcode  in  OPW  decoded opcode in IF/ID.
- if_id_rs1, if_id_rs2  in  RW  source registers in IF/ID.
- if_id_rs1_used, if_id_rs2_used  in  1  operand actually read. Applies to the non-branch class only.
- id_ex_memrd  in  1  ID/EX holds a load.
- id_ex_rd  in  RW  ID/EX destination.
- ex_mem_memrd  in  1  EX/MEM holds a load.
- ex_mem_rd  in  RW  EX/MEM destination.
- mem_busy  in  1  data memory not ready this cycle.
- PC_Write  out  1  1 = PC updates.
- if_id_Write  out  1  1 = IF/ID updates.
- id_ex_cntrl_mux_sel  out  1  1 = zero control into ID/EX (bubble).
- pipe_hold  out  1  1 = ID/EX, EX/MEM and MEM/WB hold.
- hazard_active  out  1  1 = a bubble is being inserted this cycle.
- stall_count  out  CNT_W  saturating count of bubble cycles.

## Operation
- Branch class: opcodes beq 0x44, bne 0x45, blt 0x50, bge 0x51, jr 0x08.
  - Both rs1 and rs2 are compared.
  - The used flags are ignored.
- Non-branch class: an operand is compared only when its used flag is 1.
- A match requires memrd=1, rd≠0 and rd equal to a compared operand.
- Required bubbles need:
  - Match on ID/EX: need = BR_BUBBLES (branch class) or ALU_BUBBLES (other).
  - Match on EX/MEM only: need = that value − 1, floored at 0.
  - Both stages match: take the ID/EX value.
- FSM states: RUN, HAZ (2-bit rem), MEMW (saved return state and rem).
- RUN:
  - mem_busy=1 → MEMW with saved=RUN.
  - Otherwise, need>0 → this cycle is bubble 1 (Mealy). Next state is HAZ with rem=need−1 if need>1, else RUN.
  - need=0 → normal operation.
- HAZ:
  - mem_busy=1 → MEMW with saved=HAZ and rem preserved. No bubble this cycle.
  - Otherwise, insert a bubble and decrement rem. When rem=1, next state is RUN.
  - Detection inputs are ignored in HAZ.
- MEMW:
  - Stay while mem_busy=1.
  - On mem_busy=0, that cycle behaves exactly as the saved state, including detection when saved=RUN.
- Outputs by condition:
  - Bubble: PC_Write=0, if_id_Write=0, id_ex_cntrl_mux_sel=1, pipe_hold=0, hazard_active=1.
  - Memory wait (mem_busy=1): PC_Write=0, if_id_Write=0, id_ex_cntrl_mux_sel=0, pipe_hold=1, hazard_active=0.
  - Otherwise: PC_Write=1, if_id_Write=1, all other outputs 0.
- mem_busy has priority over hazard in every state.
- stall_count increments by 1 on each edge where hazard_active=1 and saturates at all-ones.

## Timing
- Reset is evaluated only at clock edges. Any cycle with rst=0 sets state=RUN, rem=0, stall_count=0 at the edge.
- While rst=0, outputs are forced to: PC_Write=1, if_id_Write=1, mux_sel=0, pipe_hold=0, hazard_active=0.
- Reset mid-HAZ or mid-MEMW abandons remaining bubbles.
- Detection is combinational. The first bubble appears in the same cycle the hazard is visible, with zero latency.
- A stall of N bubbles holds PC/IF/ID for exactly N consecutive non-busy cycles. mem_busy cycles do not count toward N.
- stall_count updates one edge after the bubble cycle.

## Test plan
- **BR_BUBBLES=1, lw x5 in ID/EX, beq x5,x0 in IF/ID.** Exactly 1 cycle with PC_Write=0 and mux_sel=1, then normal operation. stall_count=1.
- **BR_BUBBLES=2, same pair.** 2 bubble cycles; the second occurs in HAZ with detection inputs zeroed. Separately, with lw x5 in EX/MEM only, exactly 1 bubble.
- **ALU_BUBBLES=0, then 1; lw x7 then add x8,x7 (rs1_used=1).** 0 stalls with ALU_BUBBLES=0, 1 stall with ALU_BUBBLES=1. With rs1_used=0 there is no stall. With id_ex_rd=0 there is never a stall.
- **BR_BUBBLES=3, mem_busy raised for 4 cycles after bubble 1.**
  - 4 cycles with pipe_hold=1 and mux_sel=0.
  - Then 2 more bubbles, for a total of 3.
  - stall_count=3.
- **rst=0 asserted during HAZ.** Next cycle has outputs at their normal values and stall_count=0. With CNT_W=2 and 5 bubbles, stall_count holds at 3.
